// File: rtl/wb_frame_dma_seq.sv
// wb_frame_dma_seq - Wishbone classic master sequencing load, compute and readback of one accelerator frame job.
// Every output is a register; the combinational process computes the next value of every register.
module wb_frame_dma_seq #(
  parameter int ADR_W   = 22,
  parameter int DAT_W   = 32,
  parameter int ADR_INC = 4,
  parameter int LEN_W   = 20,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [ADR_W-1:0] wr_base,
  input  logic [LEN_W-1:0] wr_words,
  input  logic [ADR_W-1:0] rd_base,
  input  logic [LEN_W-1:0] rd_words,
  input  logic [TO_W-1:0]  ack_to,
  input  logic [TO_W-1:0]  done_to,
  input  logic [DAT_W-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [DAT_W-1:0] snk_data,
  output logic             snk_valid,
  input  logic             snk_ready,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  output logic             acc_start,
  input  logic             acc_done,
  output logic             busy,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_FETCH, S_WR_BUS, S_START, S_WAIT_DONE, S_RD_BUS, S_RD_PUSH, S_FINISH
  } state_t;

  localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(ADR_INC);

  state_t           r_state, w_state;
  logic [LEN_W-1:0] r_wr_words, w_wr_words, r_rd_words, w_rd_words, r_cnt, w_cnt;
  logic [ADR_W-1:0] r_rd_base, w_rd_base, r_adr, w_adr;
  logic [TO_W-1:0]  r_ack_to, w_ack_to, r_done_to, w_done_to, r_to_cnt, w_to_cnt;
  logic [DAT_W-1:0] r_snk_data, w_snk_data, r_dat, w_dat;
  logic             r_src_ready, w_src_ready, r_snk_valid, w_snk_valid;
  logic             r_cyc, w_cyc, r_stb, w_stb, r_we, w_we, r_acc_start, w_acc_start;
  logic             r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [1:0]       r_err_code, w_err_code;

  logic [LEN_W-1:0] w_cnt_inc;
  logic [TO_W-1:0]  w_to_inc;
  logic             w_ack_exp, w_done_exp;

  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_to_inc   = r_to_cnt + TO_W'(1);
  assign w_ack_exp  = (r_ack_to != '0) && (w_to_inc == r_ack_to);
  assign w_done_exp = (r_done_to != '0) && (w_to_inc == r_done_to);

  always_comb begin
    w_state     = r_state;
    w_wr_words  = r_wr_words;
    w_rd_words  = r_rd_words;
    w_rd_base   = r_rd_base;
    w_ack_to    = r_ack_to;
    w_done_to   = r_done_to;
    w_cnt       = r_cnt;
    w_to_cnt    = '0;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_snk_data  = r_snk_data;
    w_src_ready = r_src_ready;
    w_snk_valid = r_snk_valid;
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_we        = r_we;
    w_acc_start = r_acc_start;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_err       = r_err;
    w_err_code  = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_wr_words = wr_words;
          w_rd_words = rd_words;
          w_rd_base  = rd_base;
          w_ack_to   = ack_to;
          w_done_to  = done_to;
          w_cnt      = '0;
          w_adr      = wr_base;
          w_busy     = 1'b1;
          w_err      = 1'b0;
          w_err_code = 2'd0;
          if (wr_words != '0) begin
            w_cyc       = 1'b1;
            w_we        = 1'b1;
            w_src_ready = 1'b1;
            w_state     = S_WR_FETCH;
          end else begin
            w_state = S_START;
          end
        end
      end
      S_WR_FETCH: begin
        if (src_valid) begin
          w_dat       = src_data;
          w_stb       = 1'b1;
          w_src_ready = 1'b0;
          w_state     = S_WR_BUS;
        end
      end
      S_WR_BUS: begin
        if (ack_i) begin
          w_stb = 1'b0;
          w_adr = r_adr + ADR_STEP;
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == r_wr_words) begin
            w_cyc   = 1'b0;
            w_we    = 1'b0;
            w_state = S_START;
          end else begin
            w_src_ready = 1'b1;
            w_state     = S_WR_FETCH;
          end
        end else if (w_ack_exp) begin
          w_cyc      = 1'b0;
          w_stb      = 1'b0;
          w_we       = 1'b0;
          w_err      = 1'b1;
          w_err_code = 2'd1;
          w_state    = S_FINISH;
        end else begin
          w_to_cnt = w_to_inc;
        end
      end
      S_START: begin
        w_acc_start = 1'b1;
        w_state     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (acc_done) begin
          w_acc_start = 1'b0;
          w_cnt       = '0;
          if (r_rd_words != '0) begin
            w_adr   = r_rd_base;
            w_cyc   = 1'b1;
            w_we    = 1'b0;
            w_stb   = 1'b1;
            w_state = S_RD_BUS;
          end else begin
            w_state = S_FINISH;
          end
        end else if (w_done_exp) begin
          w_acc_start = 1'b0;
          w_err       = 1'b1;
          w_err_code  = 2'd2;
          w_state     = S_FINISH;
        end else begin
          w_to_cnt = w_to_inc;
        end
      end
      S_RD_BUS: begin
        if (ack_i) begin
          w_snk_data  = dat_i;
          w_snk_valid = 1'b1;
          w_stb       = 1'b0;
          w_state     = S_RD_PUSH;
        end else if (w_ack_exp) begin
          w_cyc      = 1'b0;
          w_stb      = 1'b0;
          w_err      = 1'b1;
          w_err_code = 2'd1;
          w_state    = S_FINISH;
        end else begin
          w_to_cnt = w_to_inc;
        end
      end
      S_RD_PUSH: begin
        if (snk_ready) begin
          w_snk_valid = 1'b0;
          w_adr       = r_adr + ADR_STEP;
          w_cnt       = w_cnt_inc;
          if (w_cnt_inc == r_rd_words) begin
            w_cyc   = 1'b0;
            w_state = S_FINISH;
          end else begin
            w_stb   = 1'b1;
            w_state = S_RD_BUS;
          end
        end
      end
      S_FINISH: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    // Abort overrides whatever the phase decided this cycle, including ack, done and timeouts.
    if (abort && r_state != S_IDLE && r_state != S_FINISH) begin
      w_cyc       = 1'b0;
      w_stb       = 1'b0;
      w_we        = 1'b0;
      w_acc_start = 1'b0;
      w_src_ready = 1'b0;
      w_snk_valid = 1'b0;
      w_to_cnt    = '0;
      w_err       = 1'b1;
      w_err_code  = 2'd3;
      w_state     = S_FINISH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_words  <= '0;
      r_rd_words  <= '0;
      r_rd_base   <= '0;
      r_ack_to    <= '0;
      r_done_to   <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_snk_data  <= '0;
      r_src_ready <= 1'b0;
      r_snk_valid <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_acc_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_state     <= w_state;
      r_wr_words  <= w_wr_words;
      r_rd_words  <= w_rd_words;
      r_rd_base   <= w_rd_base;
      r_ack_to    <= w_ack_to;
      r_done_to   <= w_done_to;
      r_cnt       <= w_cnt;
      r_to_cnt    <= w_to_cnt;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_snk_data  <= w_snk_data;
      r_src_ready <= w_src_ready;
      r_snk_valid <= w_snk_valid;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_acc_start <= w_acc_start;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_err_code  <= w_err_code;
    end
  end

  assign src_ready = r_src_ready;
  assign snk_data  = r_snk_data;
  assign snk_valid = r_snk_valid;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign acc_start = r_acc_start;
  assign busy      = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_wb_frame_dma_seq.sv
// tb/tb_wb_frame_dma_seq.sv - job table plus hand sequences; write and readback scoreboards against a slave/source/sink/accelerator model.
module tb_wb_frame_dma_seq;
  localparam int ADR_W = 22;
  localparam int DAT_W = 32;
  localparam int LEN_W = 20;
  localparam int TO_W  = 16;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0, abort = 1'b0;
  logic [ADR_W-1:0] wr_base = '0, rd_base = '0;
  logic [LEN_W-1:0] wr_words = '0, rd_words = '0;
  logic [TO_W-1:0]  ack_to = '0, done_to = '0;
  logic [DAT_W-1:0] src_data = '0, dat_i = '0;
  logic src_valid = 1'b0, snk_ready = 1'b0, ack_i = 1'b0, acc_done = 1'b0;
  logic src_ready, snk_valid, cyc_o, stb_o, we_o, acc_start, busy, done_o, err_o;
  logic [DAT_W-1:0] snk_data, dat_o;
  logic [ADR_W-1:0] adr_o;
  logic [1:0] err_code;

  wb_frame_dma_seq dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .wr_base(wr_base), .wr_words(wr_words), .rd_base(rd_base), .rd_words(rd_words),
    .ack_to(ack_to), .done_to(done_to),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .acc_start(acc_start), .acc_done(acc_done),
    .busy(busy), .done_o(done_o), .err_o(err_o), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADR_W-1:0] wr_base;
    int wr_words;
    logic [ADR_W-1:0] rd_base;
    int rd_words;
    int ack_to, done_to, ack_lat, done_lat, src_tog, snk_stall, nack_idx;
    int exp_code, exp_wr, exp_rd, exp_stb_run, exp_start_run;
  } job_t;

  int checks = 0, errors = 0;
  int ack_lat = 0, done_lat = 0, src_toggle = 0, snk_stall = 0, nack_idx = 0, cur_job = 0;
  int wcnt = 0, acc_cnt = 0, src_idx = 0, src_n = 0, snk_wait = 0;
  int done_cnt = 0, wr_acks = 0, snk_cnt = 0;
  int stb_run = 0, last_stb_run = 0, start_run = 0, last_start_run = 0;
  logic src_fired = 1'b0, src_tog = 1'b0, snk_hold = 1'b0;
  logic [DAT_W-1:0] snk_prev = '0;
  logic [ADR_W-1:0] cur_wr_base = '0;
  logic [ADR_W+DAT_W-1:0] wr_q[$];
  logic [DAT_W-1:0] rd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] rd_model(input logic [ADR_W-1:0] a);
    return {10'h2B5, a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [DAT_W-1:0] src_word(input int job, input int idx);
    return 32'hC0DE_0000 ^ (32'(job) << 12) ^ 32'(idx);
  endfunction

  // Slave, source, sink and accelerator models plus scoreboard pops, all evaluated on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      ack_i = 1'b0; dat_i = '0; wcnt = 0; src_valid = 1'b0; src_fired = 1'b0;
      snk_ready = 1'b0; snk_hold = 1'b0; acc_done = 1'b0; acc_cnt = 0; stb_run = 0; start_run = 0;
    end else begin
      if (done_o) done_cnt++;
      if (stb_o) stb_run++;
      else begin
        if (stb_run != 0) last_stb_run = stb_run;
        stb_run = 0;
      end
      if (acc_start) start_run++;
      else begin
        if (start_run != 0) last_start_run = start_run;
        start_run = 0;
      end
      if (!acc_start) begin
        acc_done = 1'b0; acc_cnt = 0;
      end else if (done_lat >= 0 && acc_cnt >= done_lat) acc_done = 1'b1;
      else acc_cnt++;
      if (ack_i) begin
        ack_i = 1'b0; wcnt = 0;
      end else if (cyc_o && stb_o) begin
        if (we_o && nack_idx != 0 && wr_acks == nack_idx - 1) wcnt = 0;
        else if (wcnt >= ack_lat) begin
          ack_i = 1'b1;
          if (we_o) begin
            logic [ADR_W+DAT_W-1:0] e;
            wr_acks++;
            chk("wr_pending", 64'(wr_q.size() != 0), 64'(1));
            if (wr_q.size() != 0) begin
              e = wr_q.pop_front();
              chk("wr_adr", 64'(adr_o), 64'(e[ADR_W+DAT_W-1:DAT_W]));
              chk("wr_dat", 64'(dat_o), 64'(e[DAT_W-1:0]));
            end
          end else dat_i = rd_model(adr_o);
        end else wcnt++;
      end else wcnt = 0;
      if (src_fired) begin
        src_idx++; src_fired = 1'b0;
      end
      src_tog = ~src_tog;
      src_valid = (src_idx < src_n) && (src_toggle == 0 || src_tog);
      src_data = src_word(cur_job, src_idx);
      if (src_valid && src_ready) begin
        wr_q.push_back({cur_wr_base + ADR_W'(src_idx * 4), src_data});
        src_fired = 1'b1;
      end
      if (snk_valid && snk_hold) chk("snk_stable", 64'(snk_data), 64'(snk_prev));
      if (!snk_valid) begin
        snk_wait = 0; snk_ready = 1'b0;
      end else if (snk_wait >= snk_stall) snk_ready = 1'b1;
      else begin
        snk_ready = 1'b0; snk_wait++;
      end
      if (snk_valid && snk_ready) begin
        snk_cnt++; snk_hold = 1'b0;
        chk("rd_pending", 64'(rd_q.size() != 0), 64'(1));
        if (rd_q.size() != 0) chk("rd_dat", 64'(snk_data), 64'(rd_q.pop_front()));
      end else begin
        snk_hold = snk_valid; snk_prev = snk_data;
      end
    end
  end

  task automatic pulse_go();
    @(negedge clk); #1 go = 1'b1;
    @(negedge clk); #1 go = 1'b0;
  endtask

  task automatic start_job(input int id, input job_t j);
    @(negedge clk); #1;
    cur_job = id; wr_base = j.wr_base; rd_base = j.rd_base;
    wr_words = LEN_W'(j.wr_words); rd_words = LEN_W'(j.rd_words);
    ack_to = TO_W'(j.ack_to); done_to = TO_W'(j.done_to);
    ack_lat = j.ack_lat; done_lat = j.done_lat; src_toggle = j.src_tog;
    snk_stall = j.snk_stall; nack_idx = j.nack_idx;
    cur_wr_base = j.wr_base; src_idx = 0; src_n = j.wr_words; src_fired = 1'b0;
    wr_q.delete(); rd_q.delete();
    done_cnt = 0; wr_acks = 0; snk_cnt = 0; last_stb_run = 0; last_start_run = 0;
    for (int i = 0; i < j.rd_words; i++) rd_q.push_back(rd_model(j.rd_base + ADR_W'(i * 4)));
    pulse_go();
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
    end
    chk(name, 64'(done_cnt != 0), 64'(1));
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{22'h000000, 4, 22'h000100, 4, 16, 100, 0, 10, 0, 0, 0, 0, 4, 4, 1, 11};
    jobs[1] = '{22'h000000, 0, 22'h000000, 0, 16, 100, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4};
    jobs[2] = '{22'h000040, 5, 22'h000200, 3, 16, 100, 1, 2, 1, 5, 0, 0, 5, 3, 2, 3};
    jobs[3] = '{22'h000020, 4, 22'h000300, 2, 8, 100, 0, 5, 0, 0, 3, 1, 2, 0, 8, 0};
    jobs[4] = '{22'h000080, 1, 22'h000400, 1, 16, 20, 0, -1, 0, 0, 0, 2, 1, 0, 0, 20};
    jobs[5] = '{22'h3FFFF8, 4, 22'h3FFFFC, 2, 16, 100, 0, 4, 1, 2, 0, 0, 4, 2, 1, 5};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", 64'({src_ready, snk_valid, cyc_o, stb_o, we_o, acc_start, busy, done_o, err_o, err_code}), 64'(0));
    chk("reset_data", 64'({adr_o, dat_o, snk_data}), 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_busy", 64'({busy, cyc_o}), 64'(0));

    for (int k = 0; k < 6; k++) begin
      start_job(k + 1, jobs[k]);
      wait_done($sformatf("job%0d_done_seen", k));
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("job%0d_err_code", k), 64'(err_code), 64'(jobs[k].exp_code));
      chk($sformatf("job%0d_err_o", k), 64'(err_o), 64'(jobs[k].exp_code != 0));
      chk($sformatf("job%0d_writes", k), 64'(wr_acks), 64'(jobs[k].exp_wr));
      chk($sformatf("job%0d_reads", k), 64'(snk_cnt), 64'(jobs[k].exp_rd));
      chk($sformatf("job%0d_done_pulses", k), 64'(done_cnt), 64'(1));
      chk($sformatf("job%0d_idle", k), 64'({busy, cyc_o, stb_o, acc_start}), 64'(0));
      if (jobs[k].exp_code == 0)
        chk($sformatf("job%0d_sb_empty", k), 64'(wr_q.size() + rd_q.size()), 64'(0));
      if (jobs[k].exp_stb_run != 0)
        chk($sformatf("job%0d_stb_run", k), 64'(last_stb_run), 64'(jobs[k].exp_stb_run));
      if (jobs[k].exp_start_run != 0)
        chk($sformatf("job%0d_start_run", k), 64'(last_start_run), 64'(jobs[k].exp_start_run));
    end

    start_job(10, jobs[0]);
    repeat (8) @(negedge clk);
    pulse_go();
    wait_done("busy_go_done_seen");
    repeat (20) @(negedge clk);
    #1;
    chk("busy_go_pulses", 64'(done_cnt), 64'(1));
    chk("busy_go_writes", 64'(wr_acks), 64'(4));
    chk("busy_go_reads", 64'(snk_cnt), 64'(4));
    chk("busy_go_idle", 64'(busy), 64'(0));

    start_job(11, '{22'h000500, 1, 22'h000600, 2, 16, 100, 0, 2, 0, 100, 0, 0, 0, 0, 0, 0});
    for (int c = 0; c < 2000 && !snk_valid; c++) begin
      @(negedge clk); #1;
    end
    chk("abort_snk_seen", 64'(snk_valid), 64'(1));
    abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    chk("abort_drop", 64'({snk_valid, cyc_o, stb_o, acc_start}), 64'(0));
    chk("abort_code", 64'({err_o, err_code}), 64'(7));
    wait_done("abort_done_seen");
    repeat (2) @(negedge clk);
    #1;
    chk("abort_pulses", 64'(done_cnt), 64'(1));
    chk("abort_idle_code", 64'({busy, err_code}), 64'(3));

    start_job(12, '{22'h000700, 4, 22'h000800, 1, 0, 100, 30, 2, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int c = 0; c < 200 && !stb_o; c++) begin
      @(negedge clk); #1;
    end
    chk("rst_stb_seen", 64'({cyc_o, stb_o}), 64'(3));
    rst = 1'b1;
    #1;
    chk("rst_async_clear", 64'({cyc_o, stb_o, we_o, busy, src_ready}), 64'(0));
    @(negedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt), 64'(0));
    chk("rst_idle", 64'({cyc_o, busy, err_o}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_frame_dma_seq.md
Name: wb_frame_dma_seq

Overview:
Synthesizable Wishbone classic-cycle master that sequences one frame job for the Sobel-class accelerators.
- Load phase: streams N words from a source port into the accelerator's memory.
- Compute phase: raises start and waits for done.
- Readback phase: reads M result words out to a sink port.
- Replaces the hand-written bench sequencer and adds parametrised widths and lengths, zero-length phase skip, ack/done timeouts, abort, and sticky error status.

Parameters:
ADR_W, 22, Wishbone byte-address width
DAT_W, 32, data width
ADR_INC, 4, byte increment per word
LEN_W, 20, word-count width
TO_W, 16, width of ack/done timeout counters; limit value 0 disables that timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
go  in  1  start job; sampled only in IDLE
abort  in  1  terminate job from any state
wr_base  in  ADR_W  load start address
wr_words  in  LEN_W  load word count, 0 = skip load
rd_base  in  ADR_W  readback start address
rd_words  in  LEN_W  readback word count, 0 = skip readback
ack_to  in  TO_W  max cycles stb waits for ack
done_to  in  TO_W  max cycles start waits for acc_done
src_data  in  DAT_W  load data
src_valid  in  1  load data valid
src_ready  out  1  load data accepted when valid&ready
snk_data  out  DAT_W  readback data
snk_valid  out  1  readback data valid
snk_ready  in  1  sink accepts
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  ADR_W  Wishbone address
dat_o  out  DAT_W  Wishbone write data
dat_i  in  DAT_W  Wishbone read data
ack_i  in  1  Wishbone acknowledge
acc_start  out  1  accelerator start (level)
acc_done  in  1  accelerator done (level)
busy  out  1  job in progress
done_o  out  1  one-cycle pulse at job end (success or error)
err_o  out  1  sticky error flag, cleared on next accepted go
err_code  out  2  0 none, 1 ack timeout, 2 done timeout, 3 abort

Behaviour:
- All outputs registered. Reset values: every output 0 (adr_o, dat_o, snk_data, err_code = 0); state IDLE.
- States: IDLE, WR_FETCH, WR_BUS, START, WAIT_DONE, RD_BUS, RD_PUSH, FINISH.
- IDLE + go:
  - Latch config, clear err_o/err_code, set busy.
  - Next state: WR_FETCH if wr_words≠0, else START.
  - go while busy is ignored.
- WR_FETCH:
  - cyc_o=1, we_o=1, src_ready=1.
  - On src_valid: dat_o←src_data, stb_o←1, go to WR_BUS.
  - src_ready drops the cycle after acceptance.
- WR_BUS:
  - Hold stb_o, adr_o, dat_o until ack_i.
  - On ack: stb_o←0, adr_o+=ADR_INC, count+1.
  - If count==wr_words, go to START and drop cyc_o; else go to WR_FETCH.
  - Exactly wr_words transfers; no overshoot.
- START: acc_start←1, go to WAIT_DONE.
- WAIT_DONE:
  - On acc_done=1: acc_start←0 (next edge).
  - Next state: RD_BUS (adr_o←rd_base, cyc_o=1, we_o=0, stb_o=1) if rd_words≠0, else FINISH.
  - acc_done already high on entry counts as done.
- RD_BUS: on ack_i, snk_data←dat_i, snk_valid←1, stb_o←0, go to RD_PUSH.
- RD_PUSH:
  - Hold snk_valid/snk_data until snk_ready.
  - Then adr_o+=ADR_INC, count+1.
  - Next state: FINISH if count==rd_words (cyc_o←0); else stb_o←1, go to RD_BUS.
- FINISH: busy←0, done_o pulses 1 cycle, go to IDLE.
- Ack timeout:
  - Counter runs while stb_o=1 and ack_i=0.
  - When count reaches ack_to (ack_to≠0): cyc/stb/we←0, err_code=1, err_o=1, go to FINISH.
  - ack_i on the same cycle as timeout expiry wins (no error).
- Done timeout: same rule in WAIT_DONE with done_to; acc_start←0, err_code=2.
- Abort:
  - Abort in any busy state: next edge drops cyc/stb/we/acc_start/src_ready/snk_valid, err_code=3, go to FINISH.
  - Abort in IDLE is ignored.
  - Abort has priority over ack, done and timeout in the same cycle.
- Address arithmetic wraps modulo 2^ADR_W.
- Counters are LEN_W bits; maximum job is 2^LEN_W−1 words per phase.
- Async reset mid-job: immediately returns all outputs to reset values; no done_o pulse.

Test Plan:
- wr_base=0, wr_words=4, rd_base=0x100, rd_words=4, slave acks 1 cycle after stb, acc_done 10 cycles after start -> 4 writes at adr 0,4,8,C with src data; acc_start high until done; 4 reads at 0x100..0x10C delivered on sink in order; one done_o pulse; err_o=0.
- wr_words=0, rd_words=0 -> no bus cycles; acc_start→done handshake only; done_o pulses 1 cycle after acc_done is seen.
- src_valid toggled 1/0 and snk_ready stalled 5 cycles per word -> no duplicated or lost words; stb_o never asserted without data; sink data stable during stall.
- Slave never acks on 3rd write, ack_to=8 -> stb high exactly 8 cycles, then cyc/stb=0, err_code=1, done_o pulse, IDLE.
- acc_done never asserted, done_to=20 -> acc_start drops after 20 cycles, err_code=2. Separately: abort during RD_PUSH -> err_code=3, snk_valid=0 next cycle.
- wr_base=0x3FFFF8 (ADR_W=22), wr_words=4 -> addresses 0x3FFFF8, 0x3FFFFC, 0x000000, 0x000004. Separately: go during busy is ignored; rst asserted mid-write clears cyc_o asynchronously.
